// File: rtl/prbs_frame_source.sv
// prbs_frame_source: link-test traffic generator. It emits back-to-back
// framed PRBS-7 bytes (sync, seq, payload, checksum) on a valid/ready
// byte stream. After each frame it inserts a gap and one idle cycle.
// Enable is only looked at between frames.
module prbs_frame_source #(
   parameter int PAYLOAD_LEN = 16,
   parameter int GAP_LEN     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sof,
   output logic        out_eof,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SYNC    = 3'd1;
   localparam logic [2:0] ST_SEQ     = 3'd2;
   localparam logic [2:0] ST_PAYLOAD = 3'd3;
   localparam logic [2:0] ST_CSUM    = 3'd4;
   localparam logic [2:0] ST_GAP     = 3'd5;

   localparam logic [7:0] SYNC_BYTE  = 8'h7E;
   localparam logic [6:0] LFSR_SEED  = 7'h7F;
   localparam logic [7:0] PLEN_M1    = 8'(PAYLOAD_LEN - 1);
   // With GAP_LEN=0 the GAP state is never entered, so the wrapped value is harmless.
   localparam logic [7:0] GLEN_M1    = 8'(GAP_LEN - 1);

   logic [2:0]  state_reg, state_next;
   logic [6:0]  lfsr_reg, lfsr_next, lfsr_adv;
   logic [7:0]  csum_reg, csum_next;
   logic [7:0]  idx_reg, idx_next;
   logic [7:0]  gap_reg, gap_next;
   logic [15:0] fc_next;
   logic [7:0]  data_next;
   logic        valid_next, sof_next, eof_next;
   logic        accept;

   // Advance x^7+x^6+1 by eight single-bit steps.
   function automatic logic [6:0] lfsr_step8(input logic [6:0] s);
      logic [6:0] t;
      t = s;
      for (int i = 0; i < 8; i++) begin
         t = {t[5:0], t[6] ^ t[5]};
      end
      return t;
   endfunction

   // Byte produced by the next eight steps; the first bit lands in bit 7.
   function automatic logic [7:0] lfsr_byte(input logic [6:0] s);
      logic [6:0] t;
      logic [7:0] b;
      t = s;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         b = {b[6:0], t[6] ^ t[5]};
         t = {t[5:0], t[6] ^ t[5]};
      end
      return b;
   endfunction

   assign accept   = out_valid && out_ready;
   assign lfsr_adv = lfsr_step8(lfsr_reg);

   // Frame sequencing: everything that moves within a frame advances only on accept.
   always_comb begin
      state_next = state_reg;
      lfsr_next  = lfsr_reg;
      csum_next  = csum_reg;
      idx_next   = idx_reg;
      gap_next   = gap_reg;
      fc_next    = frame_count;
      case (state_reg)
         ST_IDLE: begin
            if (enable) state_next = ST_SYNC;
         end
         ST_SYNC: begin
            if (accept) state_next = ST_SEQ;
         end
         ST_SEQ: begin
            if (accept) begin
               state_next = ST_PAYLOAD;
               idx_next   = '0;
            end
         end
         ST_PAYLOAD: begin
            if (accept) begin
               lfsr_next = lfsr_adv;
               csum_next = csum_reg + out_data;
               idx_next  = idx_reg + 8'd1;
               if (idx_reg == PLEN_M1) state_next = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               fc_next    = frame_count + 16'd1;
               csum_next  = '0;
               gap_next   = '0;
               state_next = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_reg == GLEN_M1) state_next = ST_IDLE;
            else                    gap_next   = gap_reg + 8'd1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output byte for the state being entered, so the registered outputs line up with the state.
   always_comb begin
      data_next  = '0;
      valid_next = 1'b0;
      sof_next   = 1'b0;
      eof_next   = 1'b0;
      case (state_next)
         ST_SYNC: begin
            data_next  = SYNC_BYTE;
            valid_next = 1'b1;
            sof_next   = 1'b1;
         end
         ST_SEQ: begin
            data_next  = frame_count[7:0];
            valid_next = 1'b1;
         end
         ST_PAYLOAD: begin
            data_next  = lfsr_byte(lfsr_next);
            valid_next = 1'b1;
         end
         ST_CSUM: begin
            data_next  = csum_next;
            valid_next = 1'b1;
            eof_next   = 1'b1;
         end
         default: ;
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         lfsr_reg    <= LFSR_SEED;
         csum_reg    <= '0;
         idx_reg     <= '0;
         gap_reg     <= '0;
         frame_count <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_eof     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_reg   <= state_next;
         lfsr_reg    <= lfsr_next;
         csum_reg    <= csum_next;
         idx_reg     <= idx_next;
         gap_reg     <= gap_next;
         frame_count <= fc_next;
         out_data    <= data_next;
         out_valid   <= valid_next;
         out_sof     <= sof_next;
         out_eof     <= eof_next;
         busy        <= (state_next != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_prbs_frame_source.sv
// Testbench for prbs_frame_source: two instances (PAYLOAD_LEN=2/GAP_LEN=4 and
// PAYLOAD_LEN=1/GAP_LEN=0) share clk, rst, enable and out_ready.
// The bench checks fixed frame tables, a randomized-backpressure scoreboard
// against a PRBS bit-recurrence model, the enable drop, the seq wrap and a
// mid-frame reset.
module tb_prbs_frame_source;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic out_ready;

   logic [7:0]  a_data, b_data;
   logic        a_valid, a_sof, a_eof, a_busy;
   logic        b_valid, b_sof, b_eof, b_busy;
   logic [15:0] a_fc, b_fc;

   always #5 clk = ~clk;

   prbs_frame_source #(.PAYLOAD_LEN(2), .GAP_LEN(4)) dut_a (
      .clk(clk), .rst(rst), .enable(enable),
      .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
      .out_sof(a_sof), .out_eof(a_eof), .busy(a_busy), .frame_count(a_fc)
   );

   prbs_frame_source #(.PAYLOAD_LEN(1), .GAP_LEN(0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable),
      .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
      .out_sof(b_sof), .out_eof(b_eof), .busy(b_busy), .frame_count(b_fc)
   );

   // Selected instance under check.
   int          sel;
   logic [7:0]  m_data;
   logic        m_valid, m_sof, m_eof, m_busy;
   logic [15:0] m_fc;

   always_comb begin
      if (sel == 0) begin
         m_data = a_data; m_valid = a_valid; m_sof = a_sof; m_eof = a_eof; m_busy = a_busy; m_fc = a_fc;
      end else begin
         m_data = b_data; m_valid = b_valid; m_sof = b_sof; m_eof = b_eof; m_busy = b_busy; m_fc = b_fc;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // PRBS output bits obey n(t) = n(t-7) ^ n(t-6); the seed 7F stands for seven prior ones.
   bit hist[$];
   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
   } beat_t;
   beat_t expq[$];
   int    frame_idx;
   int    plen;

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < 7; i++) hist.push_back(1'b1);
      expq.delete();
      frame_idx = 0;
   endfunction

   function automatic logic [7:0] model_byte();
      logic [7:0] b;
      bit n;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         n = hist[0] ^ hist[1];
         void'(hist.pop_front());
         hist.push_back(n);
         b = {b[6:0], n};
      end
      return b;
   endfunction

   function automatic void push_beat(input logic [7:0] d, input logic sof, input logic eof);
      beat_t bt;
      bt.d = d; bt.sof = sof; bt.eof = eof;
      expq.push_back(bt);
   endfunction

   function automatic void model_frame();
      logic [7:0] sum;
      logic [7:0] b;
      sum = '0;
      push_beat(8'h7E, 1'b1, 1'b0);
      push_beat(frame_idx[7:0], 1'b0, 1'b0);
      for (int i = 0; i < plen; i++) begin
         b = model_byte();
         sum = sum + b;
         push_beat(b, 1'b0, 1'b0);
      end
      push_beat(sum, 1'b0, 1'b1);
      frame_idx++;
   endfunction

   // ---------------- scoreboard cycle ----------------
   logic [7:0] p_data;
   logic       p_valid, p_sof, p_eof, p_ready;
   int         accepted;

   // Called #1 after a rising edge; drives out_ready for the next edge.
   task automatic sb_cycle(input logic rdy);
      if (p_valid && !p_ready) begin
         chk("stall_valid", m_valid, 1);
         chk("stall_data", m_data, p_data);
         chk("stall_sof", m_sof, p_sof);
         chk("stall_eof", m_eof, p_eof);
      end
      if (!m_valid) begin
         chk("novalid_sof", m_sof, 0);
         chk("novalid_eof", m_eof, 0);
      end
      out_ready = rdy;
      if (m_valid && rdy) begin
         if (expq.size() == 0) model_frame();
         chk("sb_data", m_data, expq[0].d);
         chk("sb_sof", m_sof, expq[0].sof);
         chk("sb_eof", m_eof, expq[0].eof);
         void'(expq.pop_front());
         accepted++;
      end
      p_data = m_data; p_valid = m_valid; p_sof = m_sof; p_eof = m_eof; p_ready = rdy;
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int s, input int p);
      sel = s; plen = p;
      rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
      model_reset();
      p_valid = 1'b0; p_ready = 1'b0; accepted = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_sof", m_sof, 0);
      chk("rst_eof", m_eof, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_fc", m_fc, 0);
      rst = 1'b0;
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic        en;
      logic        rdy;
      logic        v;
      logic [7:0]  d;
      logic        sof;
      logic        eof;
      logic        busy;
      logic [15:0] fc;
   } vec_t;

   vec_t tab_a[12];
   vec_t tab_b[9];

   task automatic apply_vec(input string nm, input vec_t v);
      enable = v.en; out_ready = v.rdy;
      @(posedge clk); #1;
      chk({nm, "_valid"}, m_valid, v.v);
      if (v.v) chk({nm, "_data"}, m_data, v.d);
      chk({nm, "_sof"}, m_sof, v.sof);
      chk({nm, "_eof"}, m_eof, v.eof);
      chk({nm, "_busy"}, m_busy, v.busy);
      chk({nm, "_fc"}, m_fc, v.fc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // PAYLOAD_LEN=2, GAP_LEN=4: 7E 00 02 0C 0E, 4 gap, 1 idle, 7E 01
      tab_a[0]  = '{1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 16'd0};
      tab_a[1]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
      tab_a[2]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 16'd0};
      tab_a[3]  = '{1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 16'd0};
      tab_a[4]  = '{1'b1, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b1, 1'b1, 16'd0};
      tab_a[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_a[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_a[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_a[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_a[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
      tab_a[10] = '{1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 16'd1};
      tab_a[11] = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 16'd1};
      // PAYLOAD_LEN=1, GAP_LEN=0: 7E 00 02 02, 1 idle, 7E 01 0C 0C
      tab_b[0]  = '{1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 16'd0};
      tab_b[1]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
      tab_b[2]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 16'd0};
      tab_b[3]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 16'd0};
      tab_b[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
      tab_b[5]  = '{1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 16'd1};
      tab_b[6]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_b[7]  = '{1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_b[8]  = '{1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 16'd1};

      sel = 0; plen = 2;
      rst = 1'b1; enable = 1'b0; out_ready = 1'b0;

      // First two frames, fixed vectors.
      do_reset(0, 2);
      for (int i = 0; i < 12; i++) begin
         apply_vec("tabA", tab_a[i]);
         $display("tabA vec %0d: valid=%0b data=%02h sof=%0b eof=%0b busy=%0b fc=%0d",
                  i, m_valid, m_data, m_sof, m_eof, m_busy, m_fc);
      end

      // Zero gap, single payload byte.
      do_reset(1, 1);
      for (int i = 0; i < 9; i++) begin
         apply_vec("tabB", tab_b[i]);
         $display("tabB vec %0d: valid=%0b data=%02h sof=%0b eof=%0b busy=%0b fc=%0d",
                  i, m_valid, m_data, m_sof, m_eof, m_busy, m_fc);
      end

      // Random backpressure over 100 frames.
      do_reset(0, 2);
      enable = 1'b1;
      for (int c = 0; c < 20000 && accepted < 500; c++)
         sb_cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
      chk("rand_accepted", accepted, 500);
      chk("rand_fc", m_fc, 100);
      $display("random run: accepted=%0d frames=%0d fc=%0d", accepted, frame_idx, m_fc);

      // Enable dropped during frame 0 payload.
      do_reset(0, 2);
      enable = 1'b1;
      for (int c = 0; c < 100 && accepted < 3; c++) sb_cycle(1'b1);
      enable = 1'b0;
      for (int c = 0; c < 100 && accepted < 5; c++) sb_cycle(1'b1);
      chk("drop_frame_done", accepted, 5);
      chk("drop_queue_empty", expq.size(), 0);
      for (int i = 0; i < 4; i++) begin
         chk("drop_gap_busy", m_busy, 1);
         chk("drop_gap_valid", m_valid, 0);
         sb_cycle(1'b1);
      end
      for (int i = 0; i < 10; i++) begin
         chk("drop_idle_busy", m_busy, 0);
         chk("drop_idle_valid", m_valid, 0);
         sb_cycle(1'b1);
      end
      enable = 1'b1;
      for (int c = 0; c < 100 && accepted < 10; c++) sb_cycle(1'b1);
      chk("drop_frame1_done", accepted, 10);
      chk("drop_fc", m_fc, 2);
      $display("enable drop: accepted=%0d fc=%0d", accepted, m_fc);

      // Seq byte wraps with frame_count[7:0] (257 frames of 4 bytes).
      do_reset(1, 1);
      enable = 1'b1;
      for (int c = 0; c < 5000 && accepted < 257 * 4; c++) sb_cycle(1'b1);
      chk("wrap_accepted", accepted, 257 * 4);
      chk("wrap_fc", m_fc, 257);
      $display("wrap run: accepted=%0d fc=%0d", accepted, m_fc);

      // Asynchronous reset in the middle of the payload.
      do_reset(0, 2);
      enable = 1'b1; out_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      chk("mid_pre_data", m_data, 8'h0C);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_sof", m_sof, 0);
      chk("mid_rst_eof", m_eof, 0);
      chk("mid_rst_busy", m_busy, 0);
      chk("mid_rst_fc", m_fc, 0);
      #3 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apply_vec("postrst", tab_a[i]);
         $display("postrst vec %0d: valid=%0b data=%02h sof=%0b eof=%0b",
                  i, m_valid, m_data, m_sof, m_eof);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
